comp_mac_pipe: RTL and testbench

//  Parametrised successor to the single-channel comp multiplier: N_CH-channel pipelined

---
 rtl/comp_mac_pipe_pkg.sv | 14 +
 rtl/comp_mac_pipe_mult.sv | 68 ++++++
 rtl/comp_mac_pipe.sv | 124 ++++++++++++
 tb/tb_comp_mac_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_mac_pipe_pkg.sv
// Shared sizing helpers and pipeline constants for the multi-channel comp MAC.
package comp_mac_pipe_pkg;

    localparam int MAC_LATENCY = 3;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int acc_width(input int p_size, input int guard);
        return 2 * p_size + guard;
    endfunction

endpackage

// File: rtl/comp_mac_pipe_mult.sv
// Two-stage registered multiplier: operand capture, then full-width product.
module comp_mac_pipe_mult
    import comp_mac_pipe_pkg::*;
#(
    parameter int P_SIZE = 8,
    parameter int CH_W   = 2,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       ena,
    input  logic [P_SIZE-1:0]          a,
    input  logic [P_SIZE-1:0]          b,
    input  logic [CH_W-1:0]            ch,
    input  logic                       last,
    output logic                       vld_p1,
    output logic                       last_p1,
    output logic [CH_W-1:0]            ch_p1,
    output logic signed [2*P_SIZE-1:0] prod_p1
);

    logic                       vld_p0;
    logic                       last_p0;
    logic [CH_W-1:0]            ch_p0;
    logic [P_SIZE-1:0]          a_p0;
    logic [P_SIZE-1:0]          b_p0;
    logic signed [2*P_SIZE-1:0] prod_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (clear) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= ena;
            vld_p1 <= vld_p0;
        end
    end

    // S1: operand capture
    always_ff @(posedge clk) begin
        if (ena) begin
            a_p0    <= a;
            b_p0    <= b;
            ch_p0   <= ch;
            last_p0 <= last;
        end
    end

    always_comb begin
        if (SIGNED != 0)
            prod_c = $signed({{P_SIZE{a_p0[P_SIZE-1]}}, a_p0}) *
                     $signed({{P_SIZE{b_p0[P_SIZE-1]}}, b_p0});
        else
            prod_c = $signed({{P_SIZE{1'b0}}, a_p0} * {{P_SIZE{1'b0}}, b_p0});
    end

    // S2: product register
    always_ff @(posedge clk) begin
        prod_p1 <= prod_c;
        ch_p1   <= ch_p0;
        last_p1 <= last_p0;
    end

endmodule

// File: rtl/comp_mac_pipe.sv
// N_CH-channel pipelined multiply-accumulate with per-frame result strobe.
module comp_mac_pipe
    import comp_mac_pipe_pkg::*;
#(
    parameter int P_SIZE    = 8,
    parameter int N_CH      = 4,
    parameter int ACC_GUARD = 4,
    parameter int SIGNED    = 0,
    parameter int SAT       = 1,
    localparam int ACC_W    = acc_width(P_SIZE, ACC_GUARD),
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [P_SIZE-1:0]     i_param,
    input  logic [P_SIZE-1:0]     i_param_2,
    input  logic [CH_W-1:0]       i_ch,
    input  logic                  i_last,
    input  logic                  i_clear,
    output logic [ACC_W-1:0]      o_param,
    output logic [2*P_SIZE-1:0]   o_param_2,
    output logic [CH_W-1:0]       o_ch,
    output logic                  o_ovf,
    output logic                  dv
);

    localparam int ACC_DEPTH = 1 << CH_W;
    localparam logic [CH_W:0] N_CH_V = (CH_W + 1)'(N_CH);

    logic                       ch_ok;
    logic                       vld_p1;
    logic                       last_p1;
    logic [CH_W-1:0]            ch_p1;
    logic signed [2*P_SIZE-1:0] prod_p1;

    logic signed [ACC_W-1:0]    acc_q [ACC_DEPTH];
    logic [ACC_DEPTH-1:0]       ovf_q;
    logic signed [ACC_W-1:0]    acc_cur;
    logic [ACC_W:0]             acc_x;
    logic [ACC_W:0]             prod_x;
    logic [ACC_W:0]             sum_c;
    logic                       ovf_c;
    logic [ACC_W-1:0]           res_c;

    function automatic logic ovf_fn(input logic [ACC_W:0] s);
        if (SIGNED != 0)
            return s[ACC_W] ^ s[ACC_W-1];
        return s[ACC_W];
    endfunction

    // Unsigned sums only grow, so an unsigned overflow always clamps high.
    function automatic logic [ACC_W-1:0] sat_fn(input logic [ACC_W:0] s);
        if (!ovf_fn(s))
            return s[ACC_W-1:0];
        if (SIGNED == 0)
            return '1;
        return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    assign ch_ok = ({1'b0, i_ch} < N_CH_V);

    comp_mac_pipe_mult #(
        .P_SIZE (P_SIZE),
        .CH_W   (CH_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .clear   (i_clear),
        .ena     (ena && ch_ok),
        .a       (i_param),
        .b       (i_param_2),
        .ch      (i_ch),
        .last    (i_last),
        .vld_p1  (vld_p1),
        .last_p1 (last_p1),
        .ch_p1   (ch_p1),
        .prod_p1 (prod_p1)
    );

    always_comb begin
        acc_cur = acc_q[ch_p1];
        acc_x   = {(SIGNED != 0) ? acc_cur[ACC_W-1] : 1'b0, acc_cur};
        prod_x  = {{(ACC_GUARD + 1){(SIGNED != 0) ? prod_p1[2*P_SIZE-1] : 1'b0}}, prod_p1};
        sum_c   = acc_x + prod_x;
        ovf_c   = ovf_fn(sum_c);
        res_c   = (SAT != 0) ? sat_fn(sum_c) : sum_c[ACC_W-1:0];
    end

    // S3: accumulate, emit on frame end
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ACC_DEPTH; i++) acc_q[i] <= '0;
            ovf_q     <= '0;
            dv        <= 1'b0;
            o_param   <= '0;
            o_param_2 <= '0;
            o_ch      <= '0;
            o_ovf     <= 1'b0;
        end else if (i_clear) begin
            for (int i = 0; i < ACC_DEPTH; i++) acc_q[i] <= '0;
            ovf_q <= '0;
            dv    <= 1'b0;
        end else begin
            dv <= 1'b0;
            if (vld_p1) begin
                if (last_p1) begin
                    o_param      <= res_c;
                    o_param_2    <= prod_p1;
                    o_ch         <= ch_p1;
                    o_ovf        <= ovf_q[ch_p1] | ovf_c;
                    dv           <= 1'b1;
                    acc_q[ch_p1] <= '0;
                    ovf_q[ch_p1] <= 1'b0;
                end else begin
                    acc_q[ch_p1] <= res_c;
                    ovf_q[ch_p1] <= ovf_q[ch_p1] | ovf_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_mac_pipe.sv
// Bench for comp_mac_pipe: frame table on three 16-bit variants plus a timeline model of a 3-channel unit.
module tb_comp_mac_pipe;
    import comp_mac_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ena, i_last, i_clear;
    logic [7:0] i_param, i_param_2;
    logic [1:0] ch_m;
    logic [0:0] ch_s;

    logic [19:0] m_param;  logic [15:0] m_param_2; logic [1:0] m_ch; logic m_ovf, m_dv;
    logic [15:0] s_param;  logic [15:0] s_param_2; logic [0:0] s_ch; logic s_ovf, s_dv;
    logic [15:0] w_param;  logic [15:0] w_param_2; logic [0:0] w_ch; logic w_ovf, w_dv;
    logic [15:0] g_param;  logic [15:0] g_param_2; logic [0:0] g_ch; logic g_ovf, g_dv;

    always #5 clk = ~clk;

    comp_mac_pipe #(.P_SIZE(8), .N_CH(3), .ACC_GUARD(4), .SIGNED(0), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .i_param(i_param), .i_param_2(i_param_2),
        .i_ch(ch_m), .i_last(i_last), .i_clear(i_clear), .o_param(m_param),
        .o_param_2(m_param_2), .o_ch(m_ch), .o_ovf(m_ovf), .dv(m_dv));

    comp_mac_pipe #(.P_SIZE(8), .N_CH(1), .ACC_GUARD(0), .SIGNED(0), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .i_param(i_param), .i_param_2(i_param_2),
        .i_ch(ch_s), .i_last(i_last), .i_clear(i_clear), .o_param(s_param),
        .o_param_2(s_param_2), .o_ch(s_ch), .o_ovf(s_ovf), .dv(s_dv));

    comp_mac_pipe #(.P_SIZE(8), .N_CH(1), .ACC_GUARD(0), .SIGNED(0), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .ena(ena), .i_param(i_param), .i_param_2(i_param_2),
        .i_ch(ch_s), .i_last(i_last), .i_clear(i_clear), .o_param(w_param),
        .o_param_2(w_param_2), .o_ch(w_ch), .o_ovf(w_ovf), .dv(w_dv));

    comp_mac_pipe #(.P_SIZE(8), .N_CH(2), .ACC_GUARD(0), .SIGNED(1), .SAT(1)) u_sgn (
        .clk(clk), .rst(rst), .ena(ena), .i_param(i_param), .i_param_2(i_param_2),
        .i_ch(ch_s), .i_last(i_last), .i_clear(i_clear), .o_param(g_param),
        .o_param_2(g_param_2), .o_ch(g_ch), .o_ovf(g_ovf), .dv(g_dv));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference for u_dut: samples land in their channel two edges after capture.
    typedef struct {
        int e; longint a; longint b; int ch; bit last;
    } samp_t;

    localparam longint ACC_MAX = (longint'(1) << 20) - 1;

    samp_t  pq[$];
    longint acc[3];
    bit     movf[3];
    int     edge_n = 0;
    bit     exp_dv;
    longint exp_p, exp_p2;
    int     exp_ch;
    bit     exp_ovf;

    task automatic model_edge();
        samp_t  s;
        longint p, sum;
        bit     o;
        edge_n++;
        if (!rst || i_clear) begin
            pq.delete();
            for (int i = 0; i < 3; i++) begin acc[i] = 0; movf[i] = 0; end
            exp_dv = 0;
            if (!rst) begin exp_p = 0; exp_p2 = 0; exp_ch = 0; exp_ovf = 0; end
        end else begin
            exp_dv = 0;
            if (pq.size() > 0 && pq[0].e == edge_n - 2) begin
                s   = pq.pop_front();
                p   = s.a * s.b;
                sum = acc[s.ch] + p;
                o   = (sum > ACC_MAX);
                if (o) sum = ACC_MAX;
                if (s.last) begin
                    exp_p = sum; exp_p2 = p; exp_ch = s.ch; exp_ovf = movf[s.ch] | o;
                    exp_dv = 1; acc[s.ch] = 0; movf[s.ch] = 0;
                end else begin
                    acc[s.ch] = sum; movf[s.ch] = movf[s.ch] | o;
                end
            end
            if (ena && ch_m < 3)
                pq.push_back('{edge_n, longint'(i_param), longint'(i_param_2), int'(ch_m), i_last});
        end
    endtask

    task automatic model_check();
        chk("m_dv", 32'(m_dv), 32'(exp_dv));
        chk("m_param", 32'(m_param), 32'(exp_p));
        chk("m_param_2", 32'(m_param_2), 32'(exp_p2));
        chk("m_ch", 32'(m_ch), 32'(exp_ch));
        chk("m_ovf", 32'(m_ovf), 32'(exp_ovf));
    endtask

    task automatic step(input logic e, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] c, input logic l, input logic cl);
        ena = e; i_param = a; i_param_2 = b; ch_m = c; i_last = l; i_clear = cl;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int n;
        logic [7:0] a0, b0, a1, b1, a2, b2;
        logic [15:0] sat_p;  logic sat_o;
        logic [15:0] wrap_p; logic wrap_o;
        logic [15:0] sgn_p;  logic sgn_o;
        logic [15:0] p2_u;   logic [15:0] p2_s;
    } frame_t;

    frame_t tbl[6];

    function automatic logic [7:0] pick(input int k, input logic [7:0] x0,
                                        input logic [7:0] x1, input logic [7:0] x2);
        return (k == 0) ? x0 : (k == 1) ? x1 : x2;
    endfunction

    initial begin
        int  lat;
        bit  found;
        logic [7:0] ra, rb;

        tbl[0] = '{3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd2, 16'd46, 1'b0, 16'd46, 1'b0,
                   16'd46, 1'b0, 16'd4, 16'd4};
        tbl[1] = '{2, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 16'hFFFF, 1'b1, 16'd64514, 1'b1,
                   16'd2, 1'b0, 16'hFE01, 16'h0001};
        tbl[2] = '{2, 8'd253, 8'd5, 8'd2, 8'd249, 8'd0, 8'd0, 16'd1763, 1'b0, 16'd1763, 1'b0,
                   16'hFFE3, 1'b0, 16'h01F2, 16'hFFF2};
        tbl[3] = '{1, 8'd7, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 16'd63, 1'b0, 16'd63, 1'b0,
                   16'd63, 1'b0, 16'd63, 16'd63};
        tbl[4] = '{2, 8'd128, 8'd128, 8'd128, 8'd128, 8'd0, 8'd0, 16'h8000, 1'b0, 16'h8000, 1'b0,
                   16'h7FFF, 1'b1, 16'h4000, 16'h4000};
        tbl[5] = '{3, 8'd128, 8'd127, 8'd128, 8'd127, 8'd128, 8'd127, 16'hBE80, 1'b0, 16'hBE80, 1'b0,
                   16'h8000, 1'b1, 16'h3F80, 16'hC080};

        rst = 1'b0; ch_s = 1'b0;
        step(1'b1, 8'd9, 8'd9, 2'd0, 1'b1, 1'b0);
        step(1'b1, 8'd9, 8'd9, 2'd0, 1'b1, 1'b0);
        chk("rst_dv", 32'(m_dv | s_dv | g_dv), 32'd0);
        chk("rst_param", 32'(s_param), 32'd0);
        chk("rst_ovf", 32'(s_ovf | g_ovf), 32'd0);
        rst = 1'b1;
        idle(3);

        foreach (tbl[f]) begin
            for (int k = 0; k < tbl[f].n; k++)
                step(1'b1, pick(k, tbl[f].a0, tbl[f].a1, tbl[f].a2),
                     pick(k, tbl[f].b0, tbl[f].b1, tbl[f].b2), 2'd0, k == tbl[f].n - 1, 1'b0);
            found = 0; lat = 0;
            for (int w = 1; w <= 6 && !found; w++) begin
                idle(1);
                if (s_dv) begin found = 1; lat = w; end
            end
            chk($sformatf("tbl%0d_latency", f), 32'(lat), 32'(MAC_LATENCY - 1));
            if (found) begin
                chk($sformatf("tbl%0d_sat_p", f), 32'(s_param), 32'(tbl[f].sat_p));
                chk($sformatf("tbl%0d_sat_ovf", f), 32'(s_ovf), 32'(tbl[f].sat_o));
                chk($sformatf("tbl%0d_sat_p2", f), 32'(s_param_2), 32'(tbl[f].p2_u));
                chk($sformatf("tbl%0d_sat_ch", f), 32'(s_ch), 32'd0);
                chk($sformatf("tbl%0d_wrap_dv", f), 32'(w_dv), 32'd1);
                chk($sformatf("tbl%0d_wrap_p", f), 32'(w_param), 32'(tbl[f].wrap_p));
                chk($sformatf("tbl%0d_wrap_ovf", f), 32'(w_ovf), 32'(tbl[f].wrap_o));
                chk($sformatf("tbl%0d_wrap_p2", f), 32'(w_param_2), 32'(tbl[f].p2_u));
                chk($sformatf("tbl%0d_wrap_ch", f), 32'(w_ch), 32'd0);
                chk($sformatf("tbl%0d_sgn_dv", f), 32'(g_dv), 32'd1);
                chk($sformatf("tbl%0d_sgn_p", f), 32'(g_param), 32'(tbl[f].sgn_p));
                chk($sformatf("tbl%0d_sgn_ovf", f), 32'(g_ovf), 32'(tbl[f].sgn_o));
                chk($sformatf("tbl%0d_sgn_p2", f), 32'(g_param_2), 32'(tbl[f].p2_s));
                chk($sformatf("tbl%0d_sgn_ch", f), 32'(g_ch), 32'd0);
            end
            idle(1);
            chk($sformatf("tbl%0d_strobe_len", f), 32'(s_dv | w_dv | g_dv), 32'd0);
            chk($sformatf("tbl%0d_hold", f), 32'(s_param), 32'(tbl[f].sat_p));
        end

        // Interleaved channels, back-to-back frame ends
        step(1'b1, 8'd1, 8'd1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 8'd2, 8'd2, 2'd1, 1'b0, 1'b0);
        step(1'b1, 8'd3, 8'd3, 2'd0, 1'b1, 1'b0);
        step(1'b1, 8'd4, 8'd4, 2'd1, 1'b1, 1'b0);
        chk("ilv_early", 32'(m_dv), 32'd0);
        idle(1);
        chk("ilv_ch0_dv", 32'(m_dv), 32'd1);
        chk("ilv_ch0_p", 32'(m_param), 32'd10);
        chk("ilv_ch0_ch", 32'(m_ch), 32'd0);
        idle(1);
        chk("ilv_ch1_dv", 32'(m_dv), 32'd1);
        chk("ilv_ch1_p", 32'(m_param), 32'd20);
        chk("ilv_ch1_ch", 32'(m_ch), 32'd1);
        chk("ilv_ch1_p2", 32'(m_param_2), 32'd16);

        // Clear one cycle after a frame end kills it; outputs hold
        step(1'b1, 8'd7, 8'd7, 2'd0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("clr_no_dv", 32'(m_dv), 32'd0);
        end
        chk("clr_hold", 32'(m_param), 32'd20);
        step(1'b1, 8'd9, 8'd9, 2'd2, 1'b1, 1'b1);
        idle(3);
        chk("clr_drops_ena", 32'(m_dv), 32'd0);
        step(1'b1, 8'd1, 8'd1, 2'd0, 1'b1, 1'b0);
        idle(2);
        chk("clr_next_dv", 32'(m_dv), 32'd1);
        chk("clr_next_p", 32'(m_param), 32'd1);

        // Out-of-range channel is ignored
        step(1'b1, 8'd50, 8'd50, 2'd3, 1'b1, 1'b0);
        idle(3);
        chk("bad_ch", 32'(m_dv), 32'd0);

        // Reset mid-frame discards the partial sum
        step(1'b1, 8'd10, 8'd10, 2'd2, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        step(1'b1, 8'd1, 8'd2, 2'd2, 1'b1, 1'b0);
        idle(2);
        chk("rstmid_p", 32'(m_param), 32'd2);
        chk("rstmid_ch", 32'(m_ch), 32'd2);

        for (int i = 0; i < 600; i++) begin
            ch_s = 1'($urandom_range(0, 1));
            step($urandom_range(0, 9) < 8, 8'($urandom), 8'($urandom),
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 900; i++) begin
            ra = 8'($urandom_range(200, 255));
            rb = 8'($urandom_range(200, 255));
            step($urandom_range(0, 9) < 9, ra, rb, 2'($urandom_range(0, 2)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
